branch_resolve_unit: RTL and testbench

Execute-stage branch resolver that feeds the direct-mapped BTB and drives the front end. Carries each fetched PC's BTB prediction (hit, target) through a two-entry IF→ID→EX metadata pipe. Compares the prediction with the actual outcome in EX and raises a fetch redirect on mispredict. Issues registered BTB writes for every resolved taken control-flow instruction and keeps saturating branch and mispredict counters.

---
 rtl/branch_resolve_unit.sv | 107 ++++++++++
 tb/tb_branch_resolve_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: carries the BTB prediction for each fetch
// through ID and EX, checks it against the real outcome, redirects fetch on a
// mispredict, writes the BTB for taken control flow and counts branches and
// mispredicts.
module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_hit,
  input  logic [31:0]      if_target,
  input  logic             stall,
  input  logic             flush_in,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic             ex_is_jump,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             btb_update_en,
  output logic [31:0]      btb_pc,
  output logic [31:0]      btb_target,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic        vld_p1, vld_p2;
  logic [31:0] pc_p1, pc_p2;
  logic        hit_p1, hit_p2;
  logic [31:0] tgt_p1, tgt_p2;

  logic actual_taken;
  logic resolve;
  logic mispredict;
  logic kill;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
    if (en && (cnt != {CNT_W{1'b1}}))
      return cnt + CNT_W'(1);
    return cnt;
  endfunction

  // IF -> ID -> EX metadata: valids carry the kill/stall control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (kill) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= if_valid;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      pc_p1  <= if_pc;
      hit_p1 <= if_hit;
      tgt_p1 <= if_target;
      pc_p2  <= pc_p1;
      hit_p2 <= hit_p1;
      tgt_p2 <= tgt_p1;
    end
  end

  // EX: compare prediction with outcome, redirect in the same cycle
  always_comb begin
    actual_taken   = ex_is_jump | (ex_is_br & ex_taken);
    resolve        = vld_p2 & ex_valid & ~stall & ~flush_in;
    mispredict     = 1'b0;
    redirect_pc    = 32'd0;
    if (actual_taken)
      mispredict = ~hit_p2 | (tgt_p2 != ex_target);
    else
      mispredict = hit_p2;
    redirect_valid = resolve & mispredict;
    if (redirect_valid)
      redirect_pc = actual_taken ? ex_target : (pc_p2 + 32'd4);
    kill           = flush_in | redirect_valid;
  end

  // EX -> BTB write port and performance counters, one cycle after resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_update_en <= 1'b0;
      btb_pc        <= 32'd0;
      btb_target    <= 32'd0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      btb_update_en <= resolve & actual_taken;
      if (resolve & actual_taken) begin
        btb_pc     <= pc_p2;
        btb_target <= ex_target;
      end
      br_count      <= sat_inc(br_count, resolve & (ex_is_br | ex_is_jump));
      mispred_count <= sat_inc(mispred_count, redirect_valid);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus a randomized run,
// all compared against a queue-based model of in-flight fetches.
module tb_branch_resolve_unit;

  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic          if_hit;
  logic [31:0]   if_target;
  logic          stall;
  logic          flush_in;
  logic          ex_valid;
  logic          ex_is_br;
  logic          ex_is_jump;
  logic          ex_taken;
  logic [31:0]   ex_target;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          btb_update_en;
  logic [31:0]   btb_pc;
  logic [31:0]   btb_target;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mispred_count;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_hit        (if_hit),
    .if_target     (if_target),
    .stall         (stall),
    .flush_in      (flush_in),
    .ex_valid      (ex_valid),
    .ex_is_br      (ex_is_br),
    .ex_is_jump    (ex_is_jump),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .btb_update_en (btb_update_en),
    .btb_pc        (btb_pc),
    .btb_target    (btb_target),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
  } rec_t;

  // In-flight fetches, newest at the front; index 1 is the one in EX.
  rec_t        mq[$];
  int          m_br, m_mis;
  logic        m_upd;
  logic [31:0] m_bpc, m_btgt;
  int          n_tests, n_fail;
  logic        last_rv;
  logic [31:0] last_rpc;

  function automatic logic [31:0] sat(input int n);
    return (n > MAXC) ? 32'(MAXC) : 32'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rec_t z;
    z = '0;
    mq = {};
    mq.push_back(z);
    mq.push_back(z);
    m_br = 0; m_mis = 0; m_upd = 1'b0; m_bpc = 32'd0; m_btgt = 32'd0;
  endtask

  task automatic chk_regs();
    chk("btb_update_en", 32'(btb_update_en), 32'(m_upd));
    chk("btb_pc", btb_pc, m_bpc);
    chk("btb_target", btb_target, m_btgt);
    chk("br_count", 32'(br_count), sat(m_br));
    chk("mispred_count", 32'(mispred_count), sat(m_mis));
  endtask

  // One clock cycle; called at a negative edge, returns at the next one.
  task automatic cyc(input logic ifv, input logic [31:0] ipc, input logic ihit,
                     input logic [31:0] itgt, input logic st, input logic fl,
                     input logic exv, input logic br, input logic jp,
                     input logic tk, input logic [31:0] etgt);
    rec_t        ex, r;
    logic        res, at, mis, rv;
    logic [31:0] rpc;
    if_valid = ifv; if_pc = ipc; if_hit = ihit; if_target = itgt;
    stall = st; flush_in = fl; ex_valid = exv; ex_is_br = br;
    ex_is_jump = jp; ex_taken = tk; ex_target = etgt;
    ex  = mq[1];
    res = ex.v && exv && !st && !fl;
    at  = jp || (br && tk);
    if (!res)    mis = 1'b0;
    else if (at) mis = !ex.hit || (ex.tgt != etgt);
    else         mis = ex.hit;
    rv  = res && mis;
    rpc = !rv ? 32'd0 : (at ? etgt : ex.pc + 32'd4);
    #1;
    chk("redirect_valid", 32'(redirect_valid), 32'(rv));
    chk("redirect_pc", redirect_pc, rpc);
    last_rv  = redirect_valid;
    last_rpc = redirect_pc;
    m_upd = res && at;
    if (res && at) begin
      m_bpc  = ex.pc;
      m_btgt = etgt;
    end
    if (res && (br || jp)) m_br++;
    if (rv) m_mis++;
    if (fl || rv) begin
      r = mq[0]; r.v = 1'b0; mq[0] = r;
      r = mq[1]; r.v = 1'b0; mq[1] = r;
    end else if (!st) begin
      r.v = ifv; r.pc = ipc; r.hit = ihit; r.tgt = itgt;
      void'(mq.pop_back());
      mq.push_front(r);
    end
    @(posedge clk);
    #1;
    chk_regs();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    cyc(1'b1, pc, hit, tgt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic bubble();
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic exec(input logic st, input logic fl, input logic br, input logic jp,
                      input logic tk, input logic [31:0] tgt);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, st, fl, 1'b1, br, jp, tk, tgt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_valid = 0; if_pc = 0; if_hit = 0; if_target = 0; stall = 0; flush_in = 0;
    ex_valid = 0; ex_is_br = 0; ex_is_jump = 0; ex_taken = 0; ex_target = 0;
    model_reset();
    #1;
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk_regs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    @(negedge clk);
    do_reset();

    // Cold taken jal
    fetch(32'h100, 1'b0, 32'h0);
    bubble();
    exec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200);
    chk("cold_rv", 32'(last_rv), 32'd1);
    chk("cold_rpc", last_rpc, 32'h200);
    chk("cold_upd", 32'(btb_update_en), 32'd1);
    chk("cold_bpc", btb_pc, 32'h100);
    chk("cold_btgt", btb_target, 32'h200);
    bubble();
    chk("cold_upd_drop", 32'(btb_update_en), 32'd0);
    chk("cold_br", 32'(br_count), 32'd1);
    chk("cold_mis", 32'(mispred_count), 32'd1);

    // Correct prediction
    do_reset();
    fetch(32'h100, 1'b1, 32'h200);
    bubble();
    exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    chk("pred_rv", 32'(last_rv), 32'd0);
    chk("pred_upd", 32'(btb_update_en), 32'd1);
    chk("pred_btgt", btb_target, 32'h200);
    chk("pred_br", 32'(br_count), 32'd1);
    chk("pred_mis", 32'(mispred_count), 32'd0);

    // Wrong target on jalr
    do_reset();
    fetch(32'h180, 1'b1, 32'h300);
    bubble();
    exec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h240);
    chk("wtgt_rpc", last_rpc, 32'h240);
    chk("wtgt_btgt", btb_target, 32'h240);

    // False hit on a non-branch at the top of the address space
    do_reset();
    fetch(32'hFFFF_FFFC, 1'b1, 32'h40);
    bubble();
    exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234);
    chk("alias_rv", 32'(last_rv), 32'd1);
    chk("alias_rpc", last_rpc, 32'h0);
    chk("alias_upd", 32'(btb_update_en), 32'd0);
    chk("alias_br", 32'(br_count), 32'd0);
    chk("alias_mis", 32'(mispred_count), 32'd1);

    // Stall holding a mispredicting branch, then release
    do_reset();
    fetch(32'h400, 1'b0, 32'h0);
    bubble();
    for (int i = 0; i < 3; i++) begin
      exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
      chk("stall_rv", 32'(last_rv), 32'd0);
    end
    exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
    chk("release_rv", 32'(last_rv), 32'd1);
    chk("release_rpc", last_rpc, 32'h500);
    bubble();
    chk("release_mis", 32'(mispred_count), 32'd1);

    // Same, with flush_in in the release cycle
    do_reset();
    fetch(32'h400, 1'b0, 32'h0);
    bubble();
    for (int i = 0; i < 3; i++) exec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
    exec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h500);
    chk("flush_rv", 32'(last_rv), 32'd0);
    chk("flush_upd", 32'(btb_update_en), 32'd0);
    chk("flush_br", 32'(br_count), 32'd0);
    exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
    chk("flush_cleared", 32'(last_rv), 32'd0);

    // Reset asserted while an update strobe is pending
    do_reset();
    fetch(32'h100, 1'b0, 32'h0);
    bubble();
    if_valid = 0; stall = 0; flush_in = 0; ex_valid = 1; ex_is_br = 0;
    ex_is_jump = 1; ex_taken = 0; ex_target = 32'h200;
    @(posedge clk);
    #1;
    chk("mid_upd_before", 32'(btb_update_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_upd_after", 32'(btb_update_en), 32'd0);
    chk("mid_bpc", btb_pc, 32'd0);
    chk("mid_br", 32'(br_count), 32'd0);
    @(negedge clk);
    do_reset();

    // Saturation: correct-prediction stream, then cold-jump stream
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000, 1'b0, 1'b0,
          1'b1, 1'b0, 1'b1, 1'b0, 32'h2000);
    end
    chk("sat_br", 32'(br_count), 32'(MAXC));
    for (int i = 0; i < 54; i++) begin
      cyc(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0,
          1'b1, 1'b0, 1'b1, 1'b0, 32'h3800);
    end
    chk("sat_mis", 32'(mispred_count), 32'(MAXC));
    chk("sat_br_hold", 32'(br_count), 32'(MAXC));

    // Randomized run
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ipc, itgt, etgt;
      ipc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 255), 2'b00};
      itgt = 32'h100 * $urandom_range(0, 3);
      etgt = 32'h100 * $urandom_range(0, 3);
      cyc(1'($urandom_range(0, 4) != 0), ipc, 1'($urandom_range(0, 1)), itgt,
          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), etgt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
